uart_master_tx: RTL and testbench

- Serial UART transmitter; the master side of a point-to-point UART link.
- Takes an 8-bit parallel byte and shifts it out on a single serial line: start bit, LSB-first data, optional parity, stop bit.
- Signals frame completion with a one-cycle done pulse.
- Its output drives the serial line consumed by the slave receiver.

---
 rtl/uart_master_tx_if.sv | 12 +
 rtl/uart_master_tx.sv | 110 +++++++++++
 tb/tb_uart_master_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_master_tx_if.sv
// UART transmit port bundle: send request and data in, serial line and frame-done pulse out.
interface uart_master_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 en_tx;
    logic [DATA_BITS-1:0] data;
    logic                 u_tx;
    logic                 u_tx_done;

    modport master (input en_tx, input data, output u_tx, output u_tx_done);
    modport slave  (output en_tx, output data, input u_tx, input u_tx_done);
endinterface

// File: rtl/uart_master_tx.sv
// UART transmitter: start, LSB-first data, optional even parity (UART_PARITY_EN), stop.
// Latency: u_tx falls on the edge sampling en_tx; done pulses (2+DATA_BITS[+1])*CLKS_PER_BIT cycles later.
// Backpressure: en_tx and data are ignored while a frame is in flight; held en_tx restarts after one idle cycle.
module uart_master_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_master_tx_if.master bus
);
    localparam int             BCW       = $clog2(DATA_BITS);
    localparam logic [15:0]    BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic [15:0]          baud_q;
    logic [BCW-1:0]       bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 baud_end;
`ifdef UART_PARITY_EN
    logic                 par_q;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_end ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (bus.en_tx) begin
                        shift_q <= bus.data;
                        tx_q    <= 1'b0;
                        state_q <= START;
`ifdef UART_PARITY_EN
                        par_q   <= ^bus.data;
`endif
                    end
                end
                START: begin
                    if (baud_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // Present the next bit while discarding the one just sent.
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.u_tx      = tx_q;
    assign bus.u_tx_done = done_q;
endmodule

// File: tb/tb_uart_master_tx.sv
// Directed bench for uart_master_tx: expected serial bits queued at stimulus, popped per bit period.
module tb_uart_master_tx;
    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int FL = NBITS * CPB;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   prev_done = 0;
    int   rel = 0;
    logic sb[$];

    uart_master_tx_if #(.DATA_BITS(DB)) bus ();

    uart_master_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [DB-1:0] d);
        sb.push_back(1'b0);
        for (int i = 0; i < DB; i++) sb.push_back(d[i]);
`ifdef UART_PARITY_EN
        sb.push_back(^d);
`endif
        sb.push_back(1'b1);
    endtask

    // Caller is positioned at a negedge; returns at the negedge showing the done pulse.
    task automatic check_frame(input string tag);
        logic exp_bit;
        int   n;
        exp_bit = 1'b1;
        n = 0;
        while (bus.u_tx !== 1'b0 && n < 4 * FL) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, {31'd0, bus.u_tx}, 32'd0);
        if (bus.u_tx !== 1'b0) begin
            sb.delete();
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            if (i % CPB == 0) exp_bit = (sb.size() > 0) ? sb.pop_front() : 1'bx;
            chk({tag, "_bit"}, {31'd0, bus.u_tx}, {31'd0, exp_bit});
            chk({tag, "_nodone"}, {31'd0, bus.u_tx_done}, 32'd0);
        end
        @(negedge clk);
        done_cyc = cyc;
        chk({tag, "_done"}, {31'd0, bus.u_tx_done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, bus.u_tx}, 32'd1);
        chk({tag, "_len"}, done_cyc - start_cyc, FL);
    endtask

    task automatic check_idle(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk({tag, "_tx"}, {31'd0, bus.u_tx}, 32'd1);
            chk({tag, "_done"}, {31'd0, bus.u_tx_done}, 32'd0);
        end
    endtask

    initial begin
        // Reset held with a pending request: line stays idle.
        rst = 1'b1;
        bus.en_tx = 1'b1;
        bus.data = 8'h5A;
        check_idle("rst", 5);
        push_frame(8'h5A);
        rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("rel");
        chk("rel_first_edge", start_cyc - rel, 32'd1);
        check_idle("rel_after", 3);

        // Single byte, one-cycle request.
        bus.data = 8'hA5;
        bus.en_tx = 1'b1;
        push_frame(8'hA5);
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("a5");
        check_idle("a5_after", 4);

        // Back-to-back with en_tx held; second frame takes the data present at its own start.
        bus.data = 8'h3C;
        bus.en_tx = 1'b1;
        push_frame(8'h3C);
        push_frame(8'hFF);
        @(negedge clk);
        bus.data = 8'hFF;
        check_frame("b2b0");
        prev_done = done_cyc;
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("b2b1");
        chk("b2b_gap", start_cyc - prev_done, 32'd1);
        chk("b2b_done_gap", done_cyc - prev_done, FL + 1);
        check_idle("b2b_after", 4);

        // Inputs disturbed mid-frame.
        bus.data = 8'h81;
        bus.en_tx = 1'b1;
        push_frame(8'h81);
        @(negedge clk);
        fork
            check_frame("mid");
            begin
                repeat (40) @(negedge clk);
                bus.data = 8'h00;
                bus.en_tx = 1'b0;
            end
        join
        check_idle("mid_after", 4);

        // Reset at cycle 70 of a frame (data bit 3 of 0xC3 is 0 there).
        bus.data = 8'hC3;
        bus.en_tx = 1'b1;
        @(negedge clk);
        bus.en_tx = 1'b0;
        repeat (69) @(negedge clk);
        chk("pre_rst_tx", {31'd0, bus.u_tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, bus.u_tx}, 32'd1);
        chk("async_rst_done", {31'd0, bus.u_tx_done}, 32'd0);
        check_idle("rst_hold", 3);
        rst = 1'b0;
        check_idle("rst_post", 200);
        bus.data = 8'h96;
        bus.en_tx = 1'b1;
        push_frame(8'h96);
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("post_rst");
        check_idle("post_rst_after", 3);

`ifdef UART_PARITY_EN
        bus.data = 8'h07;
        bus.en_tx = 1'b1;
        push_frame(8'h07);
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("par07");
        check_idle("par07_after", 3);

        bus.data = 8'h03;
        bus.en_tx = 1'b1;
        push_frame(8'h03);
        @(negedge clk);
        bus.en_tx = 1'b0;
        check_frame("par03");
        check_idle("par03_after", 3);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
